// File: rtl/uart_sys_pkg.sv
// Shared constants for the UART command path: command bytes, FSM state encodings
// and the fixed register-file slots that receive the ALU operands.
package uart_sys_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR_ADDR = 3'd1;
  localparam state_t ST_WR_DATA = 3'd2;
  localparam state_t ST_RD_ADDR = 3'd3;
  localparam state_t ST_OP_A    = 3'd4;
  localparam state_t ST_OP_B    = 3'd5;
  localparam state_t ST_ALU_FUN = 3'd6;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  // States in which the ALU clock must already be running.
  function automatic logic alu_state(input state_t s);
    return (s == ST_OP_A) || (s == ST_OP_B) || (s == ST_ALU_FUN);
  endfunction

endpackage

// File: rtl/cmd_timeout_cnt.sv
// Idle-cycle counter for partial frames; tc flags the terminal count TIMEOUT_CYCLES-1.
module cmd_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic CLK,
  input  logic RST,
  input  logic run,
  input  logic clr,
  output logic tc
);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt;

  // Saturates at the terminal count; the FSM leaves its state on that cycle.
  always_ff @(posedge CLK) begin
    if (!RST || clr || !run) cnt <= '0;
    else if (!tc)            cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_cmd_decoder.sv
// Frame parser between the UART receiver and the register file / ALU.
// Optional partial-frame timeout is built when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_decoder
  import uart_sys_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned FUN_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  RX_PAR_ERR,
  input  logic                  RX_STP_ERR,
  output logic [ADDR_WIDTH-1:0] RF_ADDR,
  output logic [DATA_WIDTH-1:0] RF_WR_DATA,
  output logic                  RF_WR_EN,
  output logic                  RF_RD_EN,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  ALU_EN,
  output logic                  CLK_GATE_EN,
  output logic                  FRAME_ERR,
  output logic                  CMD_ERR,
  output logic                  BUSY
);

  state_t                  state, nxt;
  logic [ADDR_WIDTH-1:0]   addr_lat, addr_lat_n;
  logic [ADDR_WIDTH-1:0]   addr_n;
  logic [DATA_WIDTH-1:0]   wdata_n;
  logic [FUN_WIDTH-1:0]    fun_n;
  logic                    wr_n, rd_n, alu_n, ferr_n, cerr_n;
  logic                    tmo_hit;

`ifdef UART_CMD_TIMEOUT_EN
  logic tc;

  cmd_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .CLK (CLK),
    .RST (RST),
    .run (state != ST_IDLE),
    .clr (RX_D_VLD),
    .tc  (tc)
  );

  assign tmo_hit = tc && (state != ST_IDLE);
`else
  localparam bit TMO_OFF = (TIMEOUT_CYCLES > 0);
  assign tmo_hit = 1'b0 & TMO_OFF;
`endif

  always_comb begin
    nxt        = state;
    addr_lat_n = addr_lat;
    addr_n     = RF_ADDR;
    wdata_n    = RF_WR_DATA;
    fun_n      = ALU_FUN;
    wr_n       = 1'b0;
    rd_n       = 1'b0;
    alu_n      = 1'b0;
    ferr_n     = 1'b0;
    cerr_n     = 1'b0;
    if (RX_D_VLD) begin
      // A corrupted byte aborts whatever frame was in progress.
      if (RX_PAR_ERR || RX_STP_ERR) begin
        nxt    = ST_IDLE;
        ferr_n = 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            case (RX_P_DATA)
              CMD_RF_WR:   nxt = ST_WR_ADDR;
              CMD_RF_RD:   nxt = ST_RD_ADDR;
              CMD_ALU_OP:  nxt = ST_OP_A;
              CMD_ALU_NOP: nxt = ST_ALU_FUN;
              default:     cerr_n = 1'b1;
            endcase
          end
          ST_WR_ADDR: begin
            addr_lat_n = RX_P_DATA[ADDR_WIDTH-1:0];
            nxt        = ST_WR_DATA;
          end
          ST_WR_DATA: begin
            addr_n  = addr_lat;
            wdata_n = RX_P_DATA;
            wr_n    = 1'b1;
            nxt     = ST_IDLE;
          end
          ST_RD_ADDR: begin
            addr_n = RX_P_DATA[ADDR_WIDTH-1:0];
            rd_n   = 1'b1;
            nxt    = ST_IDLE;
          end
          ST_OP_A: begin
            addr_n  = ADDR_WIDTH'(OPA_ADDR);
            wdata_n = RX_P_DATA;
            wr_n    = 1'b1;
            nxt     = ST_OP_B;
          end
          ST_OP_B: begin
            addr_n  = ADDR_WIDTH'(OPB_ADDR);
            wdata_n = RX_P_DATA;
            wr_n    = 1'b1;
            nxt     = ST_ALU_FUN;
          end
          ST_ALU_FUN: begin
            fun_n = RX_P_DATA[FUN_WIDTH-1:0];
            alu_n = 1'b1;
            nxt   = ST_IDLE;
          end
          default: nxt = ST_IDLE;
        endcase
      end
    end else if (tmo_hit) begin
      nxt    = ST_IDLE;
      ferr_n = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= ST_IDLE;
      addr_lat    <= '0;
      RF_ADDR     <= '0;
      RF_WR_DATA  <= '0;
      RF_WR_EN    <= 1'b0;
      RF_RD_EN    <= 1'b0;
      ALU_FUN     <= '0;
      ALU_EN      <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      FRAME_ERR   <= 1'b0;
      CMD_ERR     <= 1'b0;
      BUSY        <= 1'b0;
    end else begin
      state       <= nxt;
      addr_lat    <= addr_lat_n;
      RF_ADDR     <= addr_n;
      RF_WR_DATA  <= wdata_n;
      RF_WR_EN    <= wr_n;
      RF_RD_EN    <= rd_n;
      ALU_FUN     <= fun_n;
      ALU_EN      <= alu_n;
      // Gate stays open through the ALU_EN cycle, closes on the next one.
      CLK_GATE_EN <= alu_state(nxt) || alu_n;
      FRAME_ERR   <= ferr_n;
      CMD_ERR     <= cerr_n;
      BUSY        <= (nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: stimulus pushes expected strobe events,
// a negedge monitor pops and compares whenever any strobe or error pulse appears.
module tb_uart_cmd_decoder;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] RX_P_DATA = '0;
  logic       RX_D_VLD = 1'b0, RX_PAR_ERR = 1'b0, RX_STP_ERR = 1'b0;
  logic [3:0] RF_ADDR;
  logic [7:0] RF_WR_DATA;
  logic       RF_WR_EN, RF_RD_EN;
  logic [3:0] ALU_FUN;
  logic       ALU_EN, CLK_GATE_EN, FRAME_ERR, CMD_ERR, BUSY;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  uart_cmd_decoder #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RX_PAR_ERR(RX_PAR_ERR), .RX_STP_ERR(RX_STP_ERR),
    .RF_ADDR(RF_ADDR), .RF_WR_DATA(RF_WR_DATA),
    .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN),
    .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .CLK_GATE_EN(CLK_GATE_EN),
    .FRAME_ERR(FRAME_ERR), .CMD_ERR(CMD_ERR), .BUSY(BUSY)
  );

  typedef struct {
    string      name;
    logic [4:0] flags;   // {wr, rd, alu, ferr, cerr}
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [3:0] fun;
    logic       cge;
  } ev_t;

  ev_t exp_q[$];

  function automatic ev_t mk(input string name, input logic [4:0] flags,
                             input logic [3:0] addr, input logic [7:0] wdata,
                             input logic [3:0] fun, input logic cge);
    ev_t e;
    e.name = name; e.flags = flags; e.addr = addr;
    e.wdata = wdata; e.fun = fun; e.cge = cge;
    return e;
  endfunction

  localparam logic [4:0] F_WR = 5'b10000, F_RD = 5'b01000, F_ALU = 5'b00100,
                         F_FE = 5'b00010, F_CE = 5'b00001;

  always @(negedge CLK) begin
    logic [4:0] act;
    ev_t e;
    logic ok;
    act = {RF_WR_EN, RF_RD_EN, ALU_EN, FRAME_ERR, CMD_ERR};
    if (act != 5'b0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: got flags=%b addr=%h wdata=%h fun=%h cge=%b, required no event",
                 act, RF_ADDR, RF_WR_DATA, ALU_FUN, CLK_GATE_EN);
      end else begin
        e  = exp_q.pop_front();
        ok = (act === e.flags) && (CLK_GATE_EN === e.cge);
        if (e.flags[4]) ok = ok && (RF_ADDR === e.addr) && (RF_WR_DATA === e.wdata);
        if (e.flags[3]) ok = ok && (RF_ADDR === e.addr);
        if (e.flags[2]) ok = ok && (ALU_FUN === e.fun);
        if (!ok) begin
          n_bad++;
          $display("FAIL %s: got flags=%b addr=%h wdata=%h fun=%h cge=%b, required flags=%b addr=%h wdata=%h fun=%h cge=%b",
                   e.name, act, RF_ADDR, RF_WR_DATA, ALU_FUN, CLK_GATE_EN,
                   e.flags, e.addr, e.wdata, e.fun, e.cge);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Present one byte for exactly one cycle; calls chain back-to-back.
  task automatic send(input logic [7:0] b, input logic pe = 1'b0, input logic se = 1'b0);
    RX_P_DATA = b; RX_D_VLD = 1'b1; RX_PAR_ERR = pe; RX_STP_ERR = se;
    @(posedge CLK); #1;
    RX_D_VLD = 1'b0; RX_PAR_ERR = 1'b0; RX_STP_ERR = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {RF_ADDR, RF_WR_DATA, RF_WR_EN, RF_RD_EN, ALU_FUN, ALU_EN,
               CLK_GATE_EN, FRAME_ERR, CMD_ERR, BUSY}, 32'h0);
  endtask

  initial begin
    idle(2);
    chk_all_zero("reset_outputs");
    RST = 1'b1;
    idle(1);

    // Plain register write.
    exp_q.push_back(mk("wr_a5_3c", F_WR, 4'h5, 8'h3C, 4'h0, 1'b0));
    send(8'hAA); send(8'h05); send(8'h3C);
    idle(1);
    chk("busy_after_write", BUSY, 0);

    // Register read.
    exp_q.push_back(mk("rd_aA", F_RD, 4'hA, 8'h00, 4'h0, 1'b0));
    send(8'hBB); send(8'h0A);
    idle(1);

    // ALU with operands; gate opens the cycle after CC.
    exp_q.push_back(mk("opa_12", F_WR, 4'h0, 8'h12, 4'h0, 1'b1));
    exp_q.push_back(mk("opb_34", F_WR, 4'h1, 8'h34, 4'h0, 1'b1));
    exp_q.push_back(mk("alu_f1", F_ALU, 4'h0, 8'h00, 4'h1, 1'b1));
    send(8'hCC);
    chk("gate_after_cc", CLK_GATE_EN, 1);
    chk("busy_after_cc", BUSY, 1);
    send(8'h12); send(8'h34); send(8'h01);
    chk("gate_in_alu_en", CLK_GATE_EN, 1);
    idle(1);
    chk("gate_closed", CLK_GATE_EN, 0);

    // Parity error mid-frame, then a clean write.
    exp_q.push_back(mk("par_err", F_FE, 4'h0, 8'h00, 4'h0, 1'b0));
    exp_q.push_back(mk("wr_a1_ff", F_WR, 4'h1, 8'hFF, 4'h0, 1'b0));
    send(8'hAA); send(8'h05); send(8'h77, 1'b1, 1'b0);
    send(8'hAA); send(8'h01); send(8'hFF);
    idle(1);

    // Stop error on the address byte of a read.
    exp_q.push_back(mk("stp_err", F_FE, 4'h0, 8'h00, 4'h0, 1'b0));
    send(8'hBB); send(8'h03, 1'b0, 1'b1);
    idle(1);
    chk("busy_after_stp_err", BUSY, 0);

    // Unknown command.
    exp_q.push_back(mk("cmd_err_55", F_CE, 4'h0, 8'h00, 4'h0, 1'b0));
    send(8'h55);
    chk("busy_after_55", BUSY, 0);
    idle(1);

    // Reset during OP_B; the later function byte is an unknown command.
    exp_q.push_back(mk("opa_before_rst", F_WR, 4'h0, 8'h12, 4'h0, 1'b1));
    send(8'hCC); send(8'h12);
    idle(1);
    RST = 1'b0;
    idle(1);
    chk_all_zero("reset_in_op_b");
    RST = 1'b1;
    exp_q.push_back(mk("cmd_err_02", F_CE, 4'h0, 8'h00, 4'h0, 1'b0));
    send(8'h02);
    idle(1);

`ifdef UART_CMD_TIMEOUT_EN
    // DD then silence: abort 16 cycles after the accepted byte, no ALU_EN.
    exp_q.push_back(mk("timeout", F_FE, 4'h0, 8'h00, 4'h0, 1'b0));
    send(8'hDD);
    idle(15);
    chk("tmo_not_yet", FRAME_ERR, 0);
    chk("tmo_gate_open", CLK_GATE_EN, 1);
    idle(1);
    chk("tmo_frame_err", FRAME_ERR, 1);
    chk("tmo_gate_closed", CLK_GATE_EN, 0);
    idle(1);
`endif

    idle(3);
    chk("events_pending", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
